// File: rtl/rise_period_meter_pkg.sv
// Shared types and constants for the rise-edge period meter.
package rpm_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        MEAS = 1'b1
    } state_e;

    localparam int unsigned CNT_W_DEF   = 16;
    localparam int unsigned MIN_PER_DEF = 4;

    // All-ones value of a counter of the given width (width must stay below 32).
    function automatic int unsigned cnt_max(input int unsigned width);
        return (32'd1 << width) - 32'd1;
    endfunction

    localparam int unsigned CNT_MAX = cnt_max(CNT_W_DEF);

endpackage

// File: rtl/rise_period_meter_if.sv
// Edge input, clear, and period valid/ack output port of the period meter.
interface rpm_if
    import rpm_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) ();

    logic             rise_edge;
    logic             clr;
    logic             period_ack;
    logic [CNT_W-1:0] period;
    logic             period_vld;
    logic             ovf;
    logic             miss;

    modport master (
        output rise_edge, clr, period_ack,
        input  period, period_vld, ovf, miss
    );

    modport slave (
        input  rise_edge, clr, period_ack,
        output period, period_vld, ovf, miss
    );

endinterface

// File: rtl/rpm_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module rpm_sat_cnt
    import rpm_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_at_max_c
);

    localparam logic [CNT_W-1:0] MAX_VAL = CNT_W'(cnt_max(CNT_W));

    logic [CNT_W-1:0] r_cnt;
    logic             w_at_max;

    assign w_at_max = (r_cnt == MAX_VAL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && !w_at_max) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_cnt      = r_cnt;
    assign o_at_max_c = w_at_max;

endmodule

// File: rtl/rise_period_meter.sv
// Measures clk-cycle spacing between accepted rising edges and offers each
// period on a registered valid/ack port with sticky overflow and overrun flags.
module rise_period_meter
    import rpm_pkg::*;
#(
    parameter int unsigned CNT_W   = CNT_W_DEF,
    parameter int unsigned MIN_PER = MIN_PER_DEF
) (
    input  logic  clk,
    input  logic  rst_n,
    rpm_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_MAX_W = CNT_W'(cnt_max(CNT_W));
    localparam logic [CNT_W-1:0] MIN_PER_W = CNT_W'(MIN_PER);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [CNT_W-1:0] w_cnt;
    logic             w_at_max;
    logic             w_cnt_clr;
    logic             w_cnt_inc;
    logic             w_cap;
    logic [CNT_W-1:0] w_p;
    logic             w_accept;

    logic [CNT_W-1:0] r_period;
    logic             r_vld;
    logic             r_ovf;
    logic             r_miss;

    rpm_sat_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clr      (w_cnt_clr),
        .i_inc      (w_cnt_inc),
        .o_cnt      (w_cnt),
        .o_at_max_c (w_at_max)
    );

    // Candidate period is the cycle distance to the last accepted edge.
    assign w_p      = w_at_max ? CNT_MAX_W : (w_cnt + CNT_W'(1));
    assign w_accept = (w_p >= MIN_PER_W);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_clr   = 1'b0;
        w_cnt_inc   = 1'b0;
        w_cap       = 1'b0;
        if (bus.clr) begin
            w_state_nxt = IDLE;
            w_cnt_clr   = 1'b1;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (bus.rise_edge) begin
                        w_state_nxt = MEAS;
                        w_cnt_clr   = 1'b1;
                    end
                end
                MEAS: begin
                    // Glitch edges fall through and keep the count running.
                    if (bus.rise_edge && w_accept) begin
                        w_cap     = 1'b1;
                        w_cnt_clr = 1'b1;
                    end else begin
                        w_cnt_inc = 1'b1;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // Output register: capture beats consumption; overrun marks miss.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_period <= '0;
            r_vld    <= 1'b0;
            r_ovf    <= 1'b0;
            r_miss   <= 1'b0;
        end else if (bus.clr) begin
            r_vld    <= 1'b0;
            r_ovf    <= 1'b0;
            r_miss   <= 1'b0;
        end else if (w_cap) begin
            r_period <= w_p;
            r_vld    <= 1'b1;
            if (w_p == CNT_MAX_W) begin
                r_ovf <= 1'b1;
            end
            if (r_vld && !bus.period_ack) begin
                r_miss <= 1'b1;
            end
        end else if (r_vld && bus.period_ack) begin
            r_vld <= 1'b0;
        end
    end

    assign bus.period     = r_period;
    assign bus.period_vld = r_vld;
    assign bus.ovf        = r_ovf;
    assign bus.miss       = r_miss;

endmodule

// File: tb/tb_rise_period_meter.sv
// Scoreboard bench for rise_period_meter: timestamp-based reference model,
// per-cycle expected outputs queued by the driver and checked by a monitor.
module tb_rise_period_meter;

    localparam int unsigned CNT_W   = 4;
    localparam int unsigned MIN_PER = 4;
    localparam int          MAXV    = (1 << CNT_W) - 1;

    logic clk;
    logic rst_n;

    rpm_if #(.CNT_W(CNT_W)) bus ();

    rise_period_meter #(.CNT_W(CNT_W), .MIN_PER(MIN_PER)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: edge timestamps and output state.
    int   m_t;
    bit   m_have_last;
    int   m_last;
    int   m_period;
    bit   m_vld, m_ovf, m_miss;

    longint exp_q[$];

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic longint pack_out(input int per, input bit v, input bit o, input bit m);
        return (longint'(per) << 3) | (longint'(v) << 2) | (longint'(o) << 1) | longint'(m);
    endfunction

    task automatic model_reset();
        m_have_last = 0;
        m_last      = 0;
        m_period    = 0;
        m_vld       = 0;
        m_ovf       = 0;
        m_miss      = 0;
    endtask

    task automatic model_step(input bit rise, input bit clr, input bit ack);
        int  p;
        bit  cap;
        bit  consumed;
        cap = 0;
        p   = 0;
        if (clr) begin
            m_have_last = 0;
            m_vld  = 0;
            m_ovf  = 0;
            m_miss = 0;
        end else begin
            consumed = m_vld && ack;
            if (rise) begin
                if (!m_have_last) begin
                    m_have_last = 1;
                    m_last      = m_t;
                end else begin
                    p = m_t - m_last;
                    if (p > MAXV) p = MAXV;
                    if (p >= int'(MIN_PER)) begin
                        cap    = 1;
                        m_last = m_t;
                    end
                end
            end
            if (cap) begin
                if (m_vld && !ack) m_miss = 1;
                m_period = p;
                m_vld    = 1;
                if (p == MAXV) m_ovf = 1;
            end else if (consumed) begin
                m_vld = 0;
            end
        end
        m_t++;
    endtask

    task automatic cycle(input bit rise, input bit clr, input bit ack);
        @(negedge clk);
        bus.rise_edge  = rise;
        bus.clr        = clr;
        bus.period_ack = ack;
        model_step(rise, clr, ack);
        exp_q.push_back(pack_out(m_period, m_vld, m_ovf, m_miss));
    endtask

    task automatic idle(input int n, input bit ack);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, ack);
    endtask

    task automatic edges(input int n, input int gap, input bit ack);
        for (int i = 0; i < n; i++) begin
            cycle(1'b1, 1'b0, ack);
            idle(gap - 1, ack);
        end
    endtask

    task automatic check_zero(input string nm);
        chk({nm, "_period"}, longint'(bus.period), 0);
        chk({nm, "_vld"},    longint'(bus.period_vld), 0);
        chk({nm, "_ovf"},    longint'(bus.ovf), 0);
        chk({nm, "_miss"},   longint'(bus.miss), 0);
    endtask

    // Monitor: compare DUT outputs with the queued expectation after each edge.
    always begin
        longint e;
        longint a;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = pack_out(int'(bus.period), bus.period_vld, bus.ovf, bus.miss);
            chk("cycle_outputs", a, e);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit sq, sq_d;
        rst_n          = 1'b0;
        bus.rise_edge  = 1'b0;
        bus.clr        = 1'b0;
        bus.period_ack = 1'b0;
        m_t = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;

        // Regular edges every 10 cycles, always acked.
        edges(4, 10, 1'b1);
        idle(3, 1'b1);

        // Glitch rejection: edges at 0, 2, 9.
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b1);
        idle(1, 1'b1);
        cycle(1'b1, 1'b0, 1'b1);
        idle(6, 1'b1);
        cycle(1'b1, 1'b0, 1'b1);
        idle(3, 1'b1);

        // Overrun with ack low, then clear.
        cycle(1'b0, 1'b1, 1'b0);
        edges(4, 6, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        idle(2, 1'b0);

        // Ack exactly in the capture cycle.
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 1'b0, 1'b1);
            idle(5, 1'b0);
        end

        // Saturation then a normal period; ovf stays set.
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b1);
        idle(39, 1'b1);
        cycle(1'b1, 1'b0, 1'b1);
        idle(4, 1'b1);
        cycle(1'b1, 1'b0, 1'b1);
        idle(3, 1'b1);

        // clr in the same cycle as an edge while measuring.
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b1);
        idle(6, 1'b1);
        cycle(1'b1, 1'b1, 1'b1);
        idle(6, 1'b1);
        cycle(1'b1, 1'b0, 1'b1);
        idle(7, 1'b1);
        cycle(1'b1, 1'b0, 1'b0);
        idle(4, 1'b0);

        // Async reset mid-count, off the clock edge.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("async_rst");
        bus.rise_edge  = 1'b0;
        bus.clr        = 1'b0;
        bus.period_ack = 1'b0;
        model_reset();
        exp_q.push_back(pack_out(0, 0, 0, 0));
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b1, 1'b0, 1'b1);
        idle(7, 1'b1);
        cycle(1'b1, 1'b0, 1'b1);
        idle(3, 1'b1);

        // Square wave with a 14-cycle period through a local edge detector.
        sq_d = 1'b0;
        for (int i = 0; i < 14 * 6; i++) begin
            sq = ((i % 14) < 7);
            cycle(sq && !sq_d, 1'b0, 1'b1);
            sq_d = sq;
        end

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 5) == 0), ($urandom_range(0, 59) == 0),
                  ($urandom_range(0, 2) != 0));
        end
        idle(2, 1'b0);

        @(posedge clk);
        #2;
        chk("queue_drained", longint'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/rise_period_meter.md
Name: rise_period_meter

Overview:
Consumes the single-cycle rise_edge pulse from synch_detect and measures the clk-cycle spacing between consecutive accepted rising edges. Each completed period is presented on a registered valid/ack output port to downstream logic, such as a tachometer or a baud estimator. Periods shorter than a minimum are rejected as glitches. Long periods saturate and set a sticky flag.

Parameters:
CNT_W, 16, width of the period counter and of the period output
MIN_PER, 4, smallest accepted period in clk cycles; shorter edges are ignored (range 1..2^CNT_W-1)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
rise_edge  input  1  single-cycle pulse from synch_detect, synchronous to clk
clr  input  1  synchronous clear of measurement state and flags
period  output  CNT_W  last captured period in clk cycles
period_vld  output  1  period holds an unconsumed value
period_ack  input  1  consumer takes period this cycle
ovf  output  1  sticky: a captured period saturated at 2^CNT_W-1
miss  output  1  sticky: an unacked period was overwritten

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, cnt=0, period=0, period_vld=0, ovf=0, miss=0.
- States:
  - IDLE: waiting for the first edge.
  - MEAS: counting since the last accepted edge.
- IDLE:
  - rise_edge -> go to MEAS, cnt<=0.
  - Nothing is captured on the first edge.
- MEAS, cycle without rise_edge: cnt<=cnt+1, saturating at 2^CNT_W-1 (no wrap).
- MEAS, cycle with rise_edge:
  - Candidate period p = cnt+1, saturated at 2^CNT_W-1.
  - Edges at cycles t0 and t1 therefore give p = t1-t0.
- If p < MIN_PER: the edge is ignored entirely. cnt keeps incrementing, nothing is captured, state is unchanged.
- If p >= MIN_PER (accepted edge):
  - period<=p, period_vld<=1, cnt<=0.
  - If p equals 2^CNT_W-1, ovf<=1.
- Latency: period and period_vld change on the clk edge that samples the accepted rise_edge. They are visible 1 cycle after the rise_edge cycle.
- Handshake:
  - Consumption occurs when period_vld and period_ack are both high in the same cycle; period_vld then falls on the next cycle.
  - period_ack while period_vld=0 is ignored.
  - period holds its value after consumption.
- Simultaneous capture and consumption (accepted edge in the same cycle as a consuming ack): new period is loaded, period_vld stays 1, miss is not set.
- Overrun (accepted edge while period_vld=1 and period_ack=0): period is overwritten, period_vld stays 1, miss<=1.
- Sticky flags: ovf and miss clear only via clr or reset.
- clr (synchronous):
  - Next state IDLE; cnt, period_vld, ovf and miss are cleared; period is unchanged.
  - clr has priority over rise_edge and period_ack in the same cycle.
- Reset mid-measurement: asynchronous return to reset values. The first edge after release is treated as a first edge, with no capture.
- Back-to-back rise_edge on consecutive cycles (p=1): rejected whenever MIN_PER > 1. Since synch_detect cannot produce this, it is only exercised directly.

Decomposition:
- Package rpm_pkg holds:
  - the state typedef (IDLE, MEAS);
  - the localparam CNT_MAX = 2^CNT_W-1, expressed as a function of the width.
- One sub-module: rpm_sat_cnt, a CNT_W-bit saturating up-counter with sync clear and an at_max output.
- The state machine, accept compare and output register stay in the top level.

Test Plan:
- Reset then regular edges: rise_edge pulses every 10 cycles (x4) -> no capture on the 1st edge; period=10 with period_vld=1 one cycle after each later edge; ack each -> 3 periods, miss=0, ovf=0.
- Glitch reject, MIN_PER=4: edges at t=0, 2, 9 -> the t=2 edge is ignored; single capture period=9.
- Overrun and same-cycle case:
  - Edges every 6 cycles, ack held low -> period=6 with vld=1, miss=1 after the 2nd capture.
  - Then clr -> vld=0, miss=0.
  - Repeat with ack in the exact capture cycle -> miss stays 0, vld stays 1.
- Saturation with CNT_W=4: edges 40 cycles apart -> period=15, ovf=1 sticky across the next normal 5-cycle period (period=5, ovf still 1).
- clr priority and async reset:
  - clr asserted in the same cycle as rise_edge while in MEAS -> state IDLE; the next edge gives no capture.
  - Assert rst_n low mid-count, off clock edge -> outputs 0 immediately; the next two edges 8 apart -> period=8.
- Integration: drive synch_detect.asynch_sig_in as a square wave with a 14-cycle period, feeding rise_edge -> steady period=14 with a valid every 14 cycles.
